// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, ALU/bit-op codes, FSM states and decode bundle for decode_ctrl
package ctrl_pkg;

  localparam logic [3:0] OPC_NOP  = 4'h0;
  localparam logic [3:0] OPC_ADD  = 4'h1;
  localparam logic [3:0] OPC_SUB  = 4'h2;
  localparam logic [3:0] OPC_AND  = 4'h3;
  localparam logic [3:0] OPC_OR   = 4'h4;
  localparam logic [3:0] OPC_XOR  = 4'h5;
  localparam logic [3:0] OPC_MOV  = 4'h6;
  localparam logic [3:0] OPC_LDI  = 4'h7;
  localparam logic [3:0] OPC_SWAP = 4'h8;
  localparam logic [3:0] OPC_SETB = 4'h9;
  localparam logic [3:0] OPC_CLRB = 4'hA;
  localparam logic [3:0] OPC_TGLB = 4'hB;
  localparam logic [3:0] OPC_HALT = 4'hF;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_XOR    = 3'd4,
    ALU_PASS_A = 3'd5
  } alu_op_e;

  localparam logic [1:0] BIT_SET = 2'b00;
  localparam logic [1:0] BIT_CLR = 2'b01;
  localparam logic [1:0] BIT_TGL = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DEC  = 3'd1,
    ST_EXE  = 3'd2,
    ST_WB   = 3'd3,
    ST_HLT  = 3'd4
  } state_e;

  typedef struct packed {
    alu_op_e    alu_op;
    logic       is_write;
    logic       is_swap;
    logic       is_bitop;
    logic [1:0] bit_op;
    logic       is_imm;
    logic       is_halt;
    logic       is_illegal;
  } dec_t;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational opcode decode into control bundle
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [3:0] opc,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    case (opc)
      OPC_NOP:  dec = '0;
      OPC_ADD:  begin dec.alu_op = ALU_ADD;    dec.is_write = 1'b1; end
      OPC_SUB:  begin dec.alu_op = ALU_SUB;    dec.is_write = 1'b1; end
      OPC_AND:  begin dec.alu_op = ALU_AND;    dec.is_write = 1'b1; end
      OPC_OR:   begin dec.alu_op = ALU_OR;     dec.is_write = 1'b1; end
      OPC_XOR:  begin dec.alu_op = ALU_XOR;    dec.is_write = 1'b1; end
      OPC_MOV:  begin dec.alu_op = ALU_PASS_A; dec.is_write = 1'b1; end
      OPC_LDI:  begin dec.is_write = 1'b1; dec.is_imm = 1'b1; end
      OPC_SWAP: begin dec.is_write = 1'b1; dec.is_swap = 1'b1; end
      OPC_SETB: begin dec.is_write = 1'b1; dec.is_bitop = 1'b1; dec.bit_op = BIT_SET; end
      OPC_CLRB: begin dec.is_write = 1'b1; dec.is_bitop = 1'b1; dec.bit_op = BIT_CLR; end
      OPC_TGLB: begin dec.is_write = 1'b1; dec.is_bitop = 1'b1; dec.bit_op = BIT_TGL; end
      OPC_HALT: dec.is_halt = 1'b1;
      default:  dec.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_ctrl.sv
// rtl/decode_ctrl.sv - 4-cycle decode/control stage driving the 8x16 register file
module decode_ctrl
  import ctrl_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 3,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [DW-1:0] alu_result,
  output logic [2:0]    alu_op,
  output logic [AW-1:0] read_addr_0,
  output logic [AW-1:0] read_addr_1,
  output logic [AW-1:0] reg_write_addr,
  output logic          write_en,
  output logic          swap_en,
  output logic          bit_op_en,
  output logic [1:0]    bit_op,
  output logic [3:0]    bit_position,
  output logic [DW-1:0] data_in,
  output logic          illegal,
  output logic          halted,
  output logic [CW-1:0] retired
);

  state_e        state_q, state_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [DW-1:0] wb_q, wb_d;
  logic [CW-1:0] retired_q, retired_d;
  logic          instr_ready_q, instr_ready_d;
  logic [AW-1:0] ra0_q, ra0_d, ra1_q, ra1_d, wa_q, wa_d;
  logic [2:0]    alu_op_q, alu_op_d;
  logic          write_en_q, write_en_d, swap_en_q, swap_en_d;
  logic          bit_op_en_q, bit_op_en_d, illegal_q, illegal_d, halted_q, halted_d;
  logic [1:0]    bit_op_q, bit_op_d;
  logic [3:0]    bit_pos_q, bit_pos_d;

  // In IDLE decode the incoming word so read ports are valid as DEC begins.
  logic [DW-1:0] cur;
  dec_t          dec;

  assign cur = (state_q == ST_IDLE) ? instr : instr_q;

  instr_decoder u_dec (
    .opc (cur[15:12]),
    .dec (dec)
  );

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    wb_d          = wb_q;
    retired_d     = retired_q;
    instr_ready_d = instr_ready_q;
    ra0_d         = ra0_q;
    ra1_d         = ra1_q;
    wa_d          = wa_q;
    alu_op_d      = alu_op_q;
    write_en_d    = write_en_q;
    swap_en_d     = swap_en_q;
    bit_op_en_d   = bit_op_en_q;
    bit_op_d      = bit_op_q;
    bit_pos_d     = bit_pos_q;
    illegal_d     = illegal_q;
    halted_d      = halted_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid && instr_ready_q) begin
          state_d       = ST_DEC;
          instr_d       = instr;
          instr_ready_d = 1'b0;
          ra0_d         = cur[8:6];
          ra1_d         = dec.is_swap ? cur[8:6] : cur[5:3];
          alu_op_d      = dec.alu_op;
        end
      end
      ST_DEC: begin
        if (dec.is_halt) begin
          state_d  = ST_HLT;
          halted_d = 1'b1;
          ra0_d    = '0;
          ra1_d    = '0;
          alu_op_d = '0;
        end else begin
          state_d = ST_EXE;
        end
      end
      ST_EXE: begin
        state_d     = ST_WB;
        wb_d        = dec.is_imm ? {{(DW-8){1'b0}}, cur[7:0]} : alu_result;
        write_en_d  = dec.is_write;
        swap_en_d   = dec.is_swap;
        bit_op_en_d = dec.is_bitop;
        bit_op_d    = dec.is_bitop ? dec.bit_op : 2'b00;
        bit_pos_d   = dec.is_bitop ? cur[3:0] : 4'h0;
        wa_d        = dec.is_write ? cur[11:9] : '0;
        illegal_d   = dec.is_illegal;
        retired_d   = retired_q + CW'(1);
      end
      ST_WB: begin
        state_d       = ST_IDLE;
        instr_ready_d = 1'b1;
        wb_d          = '0;
        write_en_d    = 1'b0;
        swap_en_d     = 1'b0;
        bit_op_en_d   = 1'b0;
        bit_op_d      = 2'b00;
        bit_pos_d     = 4'h0;
        wa_d          = '0;
        illegal_d     = 1'b0;
        ra0_d         = '0;
        ra1_d         = '0;
        alu_op_d      = '0;
      end
      ST_HLT: state_d = ST_HLT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      instr_q       <= '0;
      wb_q          <= '0;
      retired_q     <= '0;
      instr_ready_q <= 1'b1;
      ra0_q         <= '0;
      ra1_q         <= '0;
      wa_q          <= '0;
      alu_op_q      <= '0;
      write_en_q    <= 1'b0;
      swap_en_q     <= 1'b0;
      bit_op_en_q   <= 1'b0;
      bit_op_q      <= 2'b00;
      bit_pos_q     <= 4'h0;
      illegal_q     <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      wb_q          <= wb_d;
      retired_q     <= retired_d;
      instr_ready_q <= instr_ready_d;
      ra0_q         <= ra0_d;
      ra1_q         <= ra1_d;
      wa_q          <= wa_d;
      alu_op_q      <= alu_op_d;
      write_en_q    <= write_en_d;
      swap_en_q     <= swap_en_d;
      bit_op_en_q   <= bit_op_en_d;
      bit_op_q      <= bit_op_d;
      bit_pos_q     <= bit_pos_d;
      illegal_q     <= illegal_d;
      halted_q      <= halted_d;
    end
  end

  assign instr_ready    = instr_ready_q;
  assign alu_op         = alu_op_q;
  assign read_addr_0    = ra0_q;
  assign read_addr_1    = ra1_q;
  assign reg_write_addr = wa_q;
  assign write_en       = write_en_q;
  assign swap_en        = swap_en_q;
  assign bit_op_en      = bit_op_en_q;
  assign bit_op         = bit_op_q;
  assign bit_position   = bit_pos_q;
  assign data_in        = wb_q;
  assign illegal        = illegal_q;
  assign halted         = halted_q;
  assign retired        = retired_q;

endmodule

// File: tb/tb_decode_ctrl.sv
// tb/tb_decode_ctrl.sv - directed self-checking bench for decode_ctrl
module tb_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] alu_result;

  logic        instr_ready, write_en, swap_en, bit_op_en, illegal, halted;
  logic [2:0]  alu_op, read_addr_0, read_addr_1, reg_write_addr;
  logic [1:0]  bit_op;
  logic [3:0]  bit_position;
  logic [15:0] data_in, retired;

  logic        instr_ready_n, write_en_n, swap_en_n, bit_op_en_n, illegal_n, halted_n;
  logic [2:0]  alu_op_n, read_addr_0_n, read_addr_1_n, reg_write_addr_n;
  logic [1:0]  bit_op_n;
  logic [3:0]  bit_position_n;
  logic [15:0] data_in_n;
  logic [7:0]  retired_n;

  always #5 clk = ~clk;

  decode_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .alu_result(alu_result), .alu_op(alu_op), .read_addr_0(read_addr_0), .read_addr_1(read_addr_1),
    .reg_write_addr(reg_write_addr), .write_en(write_en), .swap_en(swap_en), .bit_op_en(bit_op_en),
    .bit_op(bit_op), .bit_position(bit_position), .data_in(data_in), .illegal(illegal),
    .halted(halted), .retired(retired)
  );

  // Narrow counter instance so the wrap boundary is reachable in a short run.
  decode_ctrl #(.CW(8)) dut_n (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready_n),
    .alu_result(alu_result), .alu_op(alu_op_n), .read_addr_0(read_addr_0_n), .read_addr_1(read_addr_1_n),
    .reg_write_addr(reg_write_addr_n), .write_en(write_en_n), .swap_en(swap_en_n), .bit_op_en(bit_op_en_n),
    .bit_op(bit_op_n), .bit_position(bit_position_n), .data_in(data_in_n), .illegal(illegal_n),
    .halted(halted_n), .retired(retired_n)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;
  int acc_cyc;
  logic [3:0]  we_h, rdy_h, ill_h;
  logic [2:0]  wa_s, ra0_s, ra1_s, aop_s;
  logic        sw_s, be_s;
  logic [1:0]  bo_s;
  logic [3:0]  bp_s;
  logic [15:0] din_s, ret_s;

  task automatic send(input logic [15:0] ins, input logic [15:0] alu);
    int n;
    instr = ins; alu_result = alu; instr_valid = 1'b1; n = 0;
    while (instr_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    n_cmp++;
    if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL send_timeout: ready=%b want 1", instr_ready); end
    @(posedge clk); #1;
    acc_cyc = cyc; instr_valid = 1'b0;
  endtask

  // Snapshot of the cycles DEC, EXE, WB, IDLE following an accept.
  task automatic observe();
    for (int k = 0; k < 4; k++) begin
      we_h[k] = write_en; rdy_h[k] = instr_ready; ill_h[k] = illegal;
      if (k == 2) begin
        wa_s = reg_write_addr; din_s = data_in; sw_s = swap_en; be_s = bit_op_en;
        bo_s = bit_op; bp_s = bit_position; ra0_s = read_addr_0; ra1_s = read_addr_1;
        aop_s = alu_op; ret_s = retired;
      end
      if (k < 3) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; instr = 16'h0; instr_valid = 1'b0; alu_result = 16'h0;
    #100;
    n_cmp++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
    n_cmp++; if ({write_en, swap_en, bit_op_en, illegal, halted} !== 5'b0) begin n_fail++; $display("FAIL reset_strobes: got %b want 00000", {write_en, swap_en, bit_op_en, illegal, halted}); end
    n_cmp++; if (retired !== 16'h0 || data_in !== 16'h0) begin n_fail++; $display("FAIL reset_ret_din: got %h/%h want 0000/0000", retired, data_in); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    send(16'h1458, 16'h1234);
    observe();
    n_cmp++; if (we_h !== 4'b0100) begin n_fail++; $display("FAIL add_we_timing: got %b want 0100", we_h); end
    n_cmp++; if (rdy_h !== 4'b1000) begin n_fail++; $display("FAIL add_ready_timing: got %b want 1000", rdy_h); end
    n_cmp++; if (wa_s !== 3'd2 || din_s !== 16'h1234) begin n_fail++; $display("FAIL add_wa_din: got %0d/%h want 2/1234", wa_s, din_s); end
    n_cmp++; if (ra0_s !== 3'd1 || ra1_s !== 3'd3 || aop_s !== 3'd0) begin n_fail++; $display("FAIL add_ports: got ra0=%0d ra1=%0d op=%0d want 1 3 0", ra0_s, ra1_s, aop_s); end
    n_cmp++; if (ret_s !== 16'd1) begin n_fail++; $display("FAIL add_retired: got %0d want 1", ret_s); end
  endtask

  task automatic test_ldi_back_to_back();
    int a1;
    send(16'h7AAB, 16'hFFFF);
    a1 = acc_cyc;
    observe();
    n_cmp++; if (wa_s !== 3'd5 || din_s !== 16'h00AB) begin n_fail++; $display("FAIL ldi_wa_din: got %0d/%h want 5/00ab", wa_s, din_s); end
    send(16'h6740, 16'h5555);
    n_cmp++; if (acc_cyc - a1 !== 4) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 4", acc_cyc - a1); end
    observe();
    n_cmp++; if (aop_s !== 3'd5 || wa_s !== 3'd3 || din_s !== 16'h5555) begin n_fail++; $display("FAIL mov: got op=%0d wa=%0d din=%h want 5 3 5555", aop_s, wa_s, din_s); end
    n_cmp++; if (ret_s !== 16'd3) begin n_fail++; $display("FAIL mov_retired: got %0d want 3", ret_s); end
  endtask

  task automatic test_swap();
    send(16'h8540, 16'h0000);
    observe();
    n_cmp++; if (we_h !== 4'b0100) begin n_fail++; $display("FAIL swap_we: got %b want 0100", we_h); end
    n_cmp++; if (sw_s !== 1'b1 || be_s !== 1'b0) begin n_fail++; $display("FAIL swap_strobes: got sw=%b be=%b want 1 0", sw_s, be_s); end
    n_cmp++; if (wa_s !== 3'd2 || ra1_s !== 3'd5) begin n_fail++; $display("FAIL swap_addr: got wa=%0d ra1=%0d want 2 5", wa_s, ra1_s); end
  endtask

  task automatic test_bitops();
    send(16'h900F, 16'h0000);
    observe();
    n_cmp++; if (we_h[2] !== 1'b1 || be_s !== 1'b1 || sw_s !== 1'b0) begin n_fail++; $display("FAIL setb_strobes: got we=%b be=%b sw=%b want 1 1 0", we_h[2], be_s, sw_s); end
    n_cmp++; if (bo_s !== 2'b00 || bp_s !== 4'hF || wa_s !== 3'd0) begin n_fail++; $display("FAIL setb_fields: got op=%b pos=%h wa=%0d want 00 f 0", bo_s, bp_s, wa_s); end
    send(16'hB003, 16'h0000);
    observe();
    n_cmp++; if (be_s !== 1'b1 || bo_s !== 2'b10 || bp_s !== 4'h3) begin n_fail++; $display("FAIL tglb_fields: got be=%b op=%b pos=%h want 1 10 3", be_s, bo_s, bp_s); end
    n_cmp++; if (ret_s !== 16'd6) begin n_fail++; $display("FAIL tglb_retired: got %0d want 6", ret_s); end
  endtask

  task automatic test_illegal();
    send(16'hC000, 16'h1111);
    observe();
    n_cmp++; if (ill_h !== 4'b0100) begin n_fail++; $display("FAIL illegal_pulse: got %b want 0100", ill_h); end
    n_cmp++; if (we_h !== 4'b0000) begin n_fail++; $display("FAIL illegal_no_we: got %b want 0000", we_h); end
    n_cmp++; if (ret_s !== 16'd7) begin n_fail++; $display("FAIL illegal_retired: got %0d want 7", ret_s); end
  endtask

  task automatic test_reset_abort();
    int we_seen;
    send(16'h1458, 16'h4321);
    @(posedge clk); #1;
    #3 rst = 1'b0;
    #1;
    n_cmp++; if (instr_ready !== 1'b1 || read_addr_0 !== 3'd0 || read_addr_1 !== 3'd0) begin n_fail++; $display("FAIL abort_async: got rdy=%b ra0=%0d ra1=%0d want 1 0 0", instr_ready, read_addr_0, read_addr_1); end
    n_cmp++; if (retired !== 16'd0) begin n_fail++; $display("FAIL abort_retired: got %0d want 0", retired); end
    we_seen = 0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (write_en !== 1'b0) we_seen++; end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (write_en !== 1'b0) we_seen++; end
    n_cmp++; if (we_seen !== 0) begin n_fail++; $display("FAIL abort_no_we: got %0d write cycles want 0", we_seen); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 255; i++) begin send(16'h0000, 16'h0000); observe(); end
    n_cmp++; if (retired_n !== 8'hFF || retired !== 16'd255) begin n_fail++; $display("FAIL wrap_pre: got %h/%0d want ff/255", retired_n, retired); end
    send(16'h0000, 16'h0000); observe();
    n_cmp++; if (retired_n !== 8'h00) begin n_fail++; $display("FAIL wrap_narrow: got %h want 00", retired_n); end
    n_cmp++; if (retired !== 16'd256) begin n_fail++; $display("FAIL wrap_wide: got %0d want 256", retired); end
  endtask

  task automatic test_halt();
    int viol;
    send(16'hF000, 16'h0000);
    instr = 16'h1458; instr_valid = 1'b1; viol = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (halted !== 1'b1 || instr_ready !== 1'b0 || write_en !== 1'b0 || halted_n !== 1'b1) viol++;
    end
    instr_valid = 1'b0;
    n_cmp++; if (viol !== 0) begin n_fail++; $display("FAIL halt_hold: got %0d bad cycles want 0", viol); end
    n_cmp++; if (retired !== 16'd256) begin n_fail++; $display("FAIL halt_retired: got %0d want 256", retired); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldi_back_to_back();
    test_swap();
    test_bitops();
    test_illegal();
    test_reset_abort();
    test_wrap();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
